// File: rtl/slices_64_sched.sv
// Job sequencer for the 64-slice MAC array: fetches input vectors, runs them through the array,
// then drains the snapshotted per-slice results one beat at a time over a valid/ready port.
`timescale 1ns/1ps
module slices_64_sched #(
  parameter int N       = 64,
  parameter int IN_W    = 256,
  parameter int Q_W     = 20,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_vec,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  input  logic [IN_W-1:0]   in_rd_data,
  output logic [IN_W-1:0]   in_array,
  output logic              mac_clear,
  input  logic              mac_valid,
  input  logic [N*Q_W-1:0]  q_flat,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [Q_W-1:0]    res_data,
  output logic [5:0]        res_slice,
  output logic [ADDR_W-1:0] res_vec
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = 6;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, COMPUTE, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] job_base, job_num, vec_cnt;
  logic [SW-1:0]     slice_idx;
  logic [TW-1:0]     tcnt;
  logic [N*Q_W-1:0]  q_snap;
  logic              mac_hit, tout, beat, last_slice, last_vec;

  function automatic logic [Q_W-1:0] pick_q(input logic [N*Q_W-1:0] snap,
                                            input logic [SW-1:0]    idx);
    return snap[int'(idx)*Q_W +: Q_W];
  endfunction

  always_comb begin
    // mac_valid is meaningless while the array is being cleared
    mac_hit    = mac_valid && !mac_clear;
    tout       = (tcnt == TW'(TIMEOUT - 1));
    beat       = (state == DRAIN) && res_ready;
    last_slice = (slice_idx == SW'(N - 1));
    last_vec   = (vec_cnt == job_num - ADDR_W'(1));
    state_nxt  = state;

    busy       = (state != IDLE) && (state != DONE);
    done       = (state == DONE);
    in_rd_en   = (state == FETCH);
    in_rd_addr = in_rd_en ? job_base + vec_cnt : '0;
    res_valid  = (state == DRAIN);
    res_data   = res_valid ? pick_q(q_snap, slice_idx) : '0;
    res_slice  = res_valid ? slice_idx : '0;
    res_vec    = res_valid ? vec_cnt : '0;

    unique case (state)
      IDLE:    if (start) state_nxt = (num_vec == '0) ? DONE : FETCH;
      FETCH:   state_nxt = WAIT_RD;
      WAIT_RD: state_nxt = COMPUTE;
      COMPUTE: begin
        if (mac_hit)   state_nxt = DRAIN;
        else if (tout) state_nxt = DONE;
      end
      DRAIN: begin
        if (beat && last_slice) state_nxt = last_vec ? DONE : FETCH;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      job_base    <= '0;
      job_num     <= '0;
      vec_cnt     <= '0;
      slice_idx   <= '0;
      tcnt        <= '0;
      err_timeout <= 1'b0;
      mac_clear   <= 1'b0;
      in_array    <= '0;
      q_snap      <= '0;
    end else begin
      state     <= state_nxt;
      mac_clear <= (state == WAIT_RD);
      unique case (state)
        IDLE: begin
          if (start) begin
            job_base    <= base_addr;
            job_num     <= num_vec;
            vec_cnt     <= '0;
            err_timeout <= 1'b0;
          end
        end
        WAIT_RD: begin
          in_array <= in_rd_data;
          tcnt     <= '0;
        end
        COMPUTE: begin
          tcnt <= tcnt + TW'(1);
          if (mac_hit) begin
            q_snap    <= q_flat;
            slice_idx <= '0;
          end else if (tout) begin
            err_timeout <= 1'b1;
          end
        end
        DRAIN: begin
          if (beat) begin
            if (!last_slice)    slice_idx <= slice_idx + SW'(1);
            else if (!last_vec) vec_cnt   <= vec_cnt + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slices_64_sched.sv
// Directed bench for slices_64_sched with a behavioural input buffer and MAC array around it.
`timescale 1ns/1ps
module tb_slices_64_sched;

  localparam int N = 64, IN_W = 256, Q_W = 20, ADDR_W = 8, TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] num_vec = '0;
  logic              busy, done, err_timeout, in_rd_en, mac_clear, res_valid;
  logic [ADDR_W-1:0] in_rd_addr, res_vec;
  logic [IN_W-1:0]   in_rd_data = '0;
  logic [IN_W-1:0]   in_array;
  logic              mac_valid = 1'b0;
  logic [N*Q_W-1:0]  q_flat = '0;
  logic              res_ready = 1'b0;
  logic [Q_W-1:0]    res_data;
  logic [5:0]        res_slice;

  slices_64_sched #(.N(N), .IN_W(IN_W), .Q_W(Q_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_vec(num_vec),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
    .in_array(in_array), .mac_clear(mac_clear), .mac_valid(mac_valid), .q_flat(q_flat),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_slice(res_slice), .res_vec(res_vec)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int beat_n = 0, clr_cnt = 0, done_cnt = 0, job_id = 0, cyc = 0, clr_cyc = 0, done_cyc = 0;
  int mac_cnt = 0;
  logic [ADDR_W-1:0] rd_q[$];
  logic [ADDR_W-1:0] last_rd = '0;
  bit mac_en = 1'b1, glitch = 1'b0, spur = 1'b0, rdy_rand = 1'b0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  function automatic logic [Q_W-1:0] qpat(input int job, input int v, input int s);
    logic [31:0] x;
    x = (32'(job) * 32'd997 + 32'(v) * 32'd64 + 32'(s)) * 32'h9E3779B1;
    return x[Q_W+5:6];
  endfunction

  function automatic logic [IN_W-1:0] vpat(input logic [ADDR_W-1:0] a);
    logic [IN_W-1:0] r;
    logic [31:0] x;
    r = '0;
    for (int k = 0; k < IN_W/32; k++) begin
      x = ({24'd0, a} + 32'(k) * 32'd301 + 32'd17) * 32'h85EBCA6B;
      r[k*32 +: 32] = x;
    end
    return r;
  endfunction

  function automatic logic [N*Q_W-1:0] junk();
    logic [N*Q_W-1:0] r;
    r = '0;
    for (int k = 0; k < N*Q_W/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [N*Q_W-1:0] qvec(input int job, input int v);
    logic [N*Q_W-1:0] r;
    r = '0;
    for (int s = 0; s < N; s++) r[s*Q_W +: Q_W] = qpat(job, v, s);
    return r;
  endfunction

  // Input buffer, MAC array and result sink models; also scores every result beat.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      mac_cnt   = 0;
      mac_valid = 1'b0;
      res_ready = 1'b0;
    end else begin
      res_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (in_rd_en) begin
        rd_q.push_back(in_rd_addr);
        last_rd    = in_rd_addr;
        in_rd_data = vpat(in_rd_addr);
      end
      if (res_valid) begin
        check_eq("res_slice", res_slice, beat_n % N);
        check_eq("res_vec",   res_vec,   beat_n / N);
        check_eq("res_data",  res_data,  qpat(job_id, beat_n / N, beat_n % N));
        if (res_ready) beat_n++;
      end
      if (mac_clear) begin
        check_eq("in_array", in_array, vpat(last_rd));
        clr_cyc   = cyc;
        clr_cnt++;
        mac_cnt   = 5;
        mac_valid = glitch;
        q_flat    = junk();
      end else if (mac_cnt != 0) begin
        mac_cnt--;
        if (mac_cnt == 0 && mac_en) begin
          mac_valid = 1'b1;
          q_flat    = qvec(job_id, clr_cnt - 1);
        end else begin
          mac_valid = 1'b0;
          q_flat    = junk();
        end
      end else begin
        mac_valid = spur && res_valid;
        q_flat    = junk();
      end
    end
  end

  task automatic prep_job();
    job_id++;
    beat_n   = 0;
    clr_cnt  = 0;
    done_cnt = 0;
    rd_q.delete();
  endtask

  task automatic run_job(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n,
                         input bit exp_to, input bit poke_busy, input bit start_in_done);
    bit got;
    int k_done;
    logic [ADDR_W-1:0] ea;
    prep_job();
    got    = 1'b0;
    k_done = -1;
    @(negedge clk);
    base_addr = b;
    num_vec   = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 8'($urandom);
    num_vec   = 8'($urandom_range(1, 255));
    for (int k = 0; k < 20000 && !got; k++) begin
      if (done) begin
        got    = 1'b1;
        k_done = k;
      end else begin
        start = poke_busy && (k == 50);
        @(negedge clk);
      end
    end
    check_eq("done_seen", got, 1'b1);
    if (n == '0) check_eq("empty_done_lat", k_done, 0);
    start = start_in_done;
    @(negedge clk);
    start = 1'b0;
    check_eq("done_pulse", done, 1'b0);
    check_eq("busy_idle", busy, 1'b0);
    @(negedge clk);
    check_eq("busy_after", busy, 1'b0);
    check_eq("done_cnt", done_cnt, 1);
    check_eq("beats", beat_n, exp_to ? 0 : int'(n) * N);
    check_eq("reads", rd_q.size(), exp_to ? 1 : int'(n));
    foreach (rd_q[i]) begin
      ea = b + ADDR_W'(i);
      check_eq("rd_addr", rd_q[i], ea);
    end
    check_eq("err_timeout", err_timeout, exp_to);
  endtask

  initial begin
    bit reached;
    #23;
    check_eq("rst_ctrl", {busy, done, err_timeout, in_rd_en, mac_clear, res_valid}, 6'd0);
    check_eq("rst_array", in_array, '0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);

    // single vector, array answers 5 cycles after clear, sink always ready
    run_job(8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    // empty job
    run_job(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    // stalling sink, mac_valid during clear and during drain must be ignored
    rdy_rand = 1'b1; glitch = 1'b1; spur = 1'b1;
    run_job(8'd20, 8'd2, 1'b0, 1'b0, 1'b0);
    rdy_rand = 1'b0; glitch = 1'b0; spur = 1'b0;
    // address wrap, start held during the done cycle
    run_job(8'd254, 8'd3, 1'b0, 1'b0, 1'b1);
    // array never answers: abort after TIMEOUT compute cycles
    mac_en = 1'b0;
    run_job(8'd7, 8'd2, 1'b1, 1'b0, 1'b0);
    check_eq("timeout_cycles", done_cyc - clr_cyc, TIMEOUT);
    mac_en = 1'b1;
    run_job(8'd9, 8'd0, 1'b0, 1'b0, 1'b0);

    // reset in the middle of draining, then a clean job with a start poked while busy
    prep_job();
    @(negedge clk);
    base_addr = 8'd10; num_vec = 8'd2; start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 2000 && !reached; k++) begin
      if (beat_n >= 10) reached = 1'b1;
      else @(negedge clk);
    end
    check_eq("mid_drain_reached", reached, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_ctrl", {busy, done, err_timeout, in_rd_en, mac_clear, res_valid}, 6'd0);
    check_eq("arst_res", {res_data, res_slice, res_vec, in_rd_addr}, '0);
    check_eq("arst_array", in_array, '0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    run_job(8'd5, 8'd1, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
